wallace_mul_pipe: RTL and testbench

- Parametrised, pipelined Wallace-tree multiplier; successor to the combinational 64-bit Wallace block.
- Takes two WIDTH-bit operands with a valid/ready handshake. Returns the product in carry-save form (s1 + s2 = a*b mod 2^(2*WIDTH)) after STAGES clocks.
- Carries a caller tag alongside each product.
- Sits in the execute-stage multiply path; the downstream adder/ALU does the final carry-propagate add.

---
 rtl/wallace_pkg.sv | 46 ++++
 rtl/wallace_mul_pipe_csa.sv | 19 +
 rtl/wallace_mul_pipe.sv | 143 ++++++++++++++
 tb/tb_wallace_mul_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
// Used by the RTL to place register ranks in the tree, and by the bench for its parameter limits.
package wallace_pkg;

  localparam int WIDTH_MIN  = 8;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 6;

  // Rows left after 'level' 3:2 compression levels, starting from 'width' partial products.
  function automatic int rows_after(input int width, input int level);
    int n;
    n = width;
    for (int i = 0; i < level; i++)
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  // Number of 3:2 levels needed to bring 'width' rows down to two.
  function automatic int wallace_levels(input int width);
    int n;
    int l;
    n = width;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  // Level after which register rank k sits: ceil(k*L/stages).
  function automatic int rank_after_level(input int k, input int levels, input int stages);
    return (k * levels + stages - 1) / stages;
  endfunction

  // How many register ranks follow a given level (several may share one when L < stages).
  function automatic int ranks_at_level(input int level, input int levels, input int stages);
    int c;
    c = 0;
    for (int k = 1; k <= stages; k++)
      if (rank_after_level(k, levels, stages) == level) c++;
    return c;
  endfunction

endpackage

// File: rtl/wallace_mul_pipe_csa.sv
// One row of 3:2 carry-save compressors, N bits wide.
// The carry vector leaves already shifted up one place; the carry out of bit N-1 is
// dropped because the whole product is only defined modulo 2^N.
module csa_row
  import wallace_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = {(x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready handshake and pass-through tag.
// Output is carry-save (s1 + s2 = a*b mod 2^(2*WIDTH)); the consumer does the final add.
// Optional feature: define WALLACE_MUL_SIGNED_EN to add the is_signed input, which selects
// Baugh-Wooley two's-complement partial products per beat.
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef WALLACE_MUL_SIGNED_EN
  input  logic                 is_signed,
`endif
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   s1,
  output logic [2*WIDTH-1:0]   s2,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int L  = wallace_levels(WIDTH);

  logic               en;
  logic               sgn;
  logic [STAGES:1]    vld_p;
  logic [TAG_W-1:0]   tag_p [1:STAGES];
  // lvl[l][i]: row i after compression level l and any ranks that follow it.
  logic [PW-1:0]      lvl [0:L][0:WIDTH-1];

  // One partial-product row; in signed mode the MSB row/column terms are inverted and
  // row 0 carries the two correction ones in bits that are otherwise always zero there.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] x, input logic yb,
                                           input logic sg, input int r);
    logic [WIDTH-1:0] t;
    logic [PW-1:0]    row;
    t = x & {WIDTH{yb}};
    if (sg) begin
      if (r == WIDTH - 1) t[WIDTH-2:0] = ~t[WIDTH-2:0];
      else                t[WIDTH-1]   = ~t[WIDTH-1];
    end
    row = {{WIDTH{1'b0}}, t} << r;
    if (sg && r == 0) begin
      row[WIDTH]  = 1'b1;
      row[PW-1]   = 1'b1;
    end
    return row;
  endfunction

`ifdef WALLACE_MUL_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  // Whole pipe moves together; a held output freezes every rank, bubbles included.
  assign out_valid = vld_p[STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  // Valid bits: the only state cleared by reset, so in-flight beats vanish at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Tag travels in lockstep with the valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      tag_p[1] <= in_tag;
      for (int k = 2; k <= STAGES; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int NO = rows_after(WIDTH, l);
    localparam int NC = ranks_at_level(l, L, STAGES);
    logic [PW-1:0] cmb [0:NO-1];

    if (l == 0) begin : g_pp
      for (genvar r = 0; r < WIDTH; r++) begin : g_row
        assign cmb[r] = pp_row(a, b[r], sgn, r);
      end
    end else begin : g_csa
      localparam int NI = rows_after(WIDTH, l - 1);
      localparam int NG = NI / 3;
      for (genvar g = 0; g < NG; g++) begin : g_grp
        csa_row #(.N(PW)) u_csa (
          .x     (lvl[l-1][3*g]),
          .y     (lvl[l-1][3*g+1]),
          .z     (lvl[l-1][3*g+2]),
          .sum   (cmb[2*g]),
          .carry (cmb[2*g+1])
        );
      end
      for (genvar p = 0; p < NI - 3 * NG; p++) begin : g_pass
        assign cmb[2*NG+p] = lvl[l-1][3*NG+p];
      end
    end

    if (NC == 0) begin : g_comb
      for (genvar i = 0; i < NO; i++) begin : g_o
        assign lvl[l][i] = cmb[i];
      end
    end else begin : g_reg
      logic [PW-1:0] stg [1:NC][0:NO-1];
      // Register rank(s) after this level; data is not reset, valid bits qualify it.
      always_ff @(posedge clk) begin
        if (en) begin
          for (int i = 0; i < NO; i++) begin
            stg[1][i] <= cmb[i];
            for (int r = 2; r <= NC; r++) stg[r][i] <= stg[r-1][i];
          end
        end
      end
      for (genvar i = 0; i < NO; i++) begin : g_o
        assign lvl[l][i] = stg[NC][i];
      end
    end

    for (genvar i = NO; i < WIDTH; i++) begin : g_zero
      assign lvl[l][i] = '0;
    end
  end

  // Outputs read as zero whenever no valid beat is presented (including during reset).
  assign s1      = out_valid ? lvl[L][0]      : '0;
  assign s2      = out_valid ? lvl[L][1]      : '0;
  assign out_tag = out_valid ? tag_p[STAGES]  : '0;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Bench for wallace_mul_pipe: a 64-bit/3-stage instance and an 8-bit/6-stage instance.
module tb_wallace_mul_pipe;
  import wallace_pkg::*;

  localparam int W   = 64;
  localparam int S   = 3;
  localparam int TW  = 4;
  localparam int W8  = WIDTH_MIN;
  localparam int S8  = STAGES_MAX;
  localparam int TW8 = 2;

  logic clk;
  logic rst_n;

  logic            in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]    a, b;
  logic [TW-1:0]   in_tag, out_tag;
  logic [2*W-1:0]  s1, s2;
  logic            is_signed;

  logic            in_valid8, in_ready8, out_valid8, out_ready8;
  logic [W8-1:0]   a8, b8;
  logic [TW8-1:0]  in_tag8, out_tag8;
  logic [2*W8-1:0] s1_8, s2_8;
  logic            is_signed8;

  int checks = 0;
  int errors = 0;

  wallace_mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef WALLACE_MUL_SIGNED_EN
    .is_signed(is_signed),
`endif
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .s1(s1), .s2(s2), .out_tag(out_tag)
  );

  wallace_mul_pipe #(.WIDTH(W8), .STAGES(S8), .TAG_W(TW8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
`ifdef WALLACE_MUL_SIGNED_EN
    .is_signed(is_signed8),
`endif
    .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s1(s1_8), .s2(s2_8), .out_tag(out_tag8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [TW-1:0]  tag;
    logic [2*W-1:0] prod;
  } wvec_t;

  typedef struct {
    logic [W8-1:0]   a;
    logic [W8-1:0]   b;
    logic            sg;
    logic [TW8-1:0]  tag;
    logic [2*W8-1:0] prod;
  } nvec_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    int            adv;
  } sb_t;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] wsum();
    return s1 + s2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wide_beat(input wvec_t v, input string nm);
    int n;
    a = v.a; b = v.b; in_tag = v.tag; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n = 1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, " latency"}, 128'(n), 128'(S));
    check({nm, " product"}, wsum(), v.prod);
    check({nm, " tag"}, 128'(out_tag), 128'(v.tag));
    tick();
    check({nm, " drained"}, 128'(out_valid), 128'(0));
  endtask

  task automatic nar_beat(input nvec_t v, input string nm);
    int n;
    logic [2*W8-1:0] sum8;
    a8 = v.a; b8 = v.b; in_tag8 = v.tag; in_valid8 = 1'b1;
`ifdef WALLACE_MUL_SIGNED_EN
    is_signed8 = v.sg;
`endif
    tick();
    n = 1;
    in_valid8 = 1'b0;
    while (!out_valid8 && n < 20) begin
      tick();
      n++;
    end
    sum8 = s1_8 + s2_8;
    check({nm, " latency"}, 128'(n), 128'(S8));
    check({nm, " product"}, 128'(sum8), 128'(v.prod));
    check({nm, " tag"}, 128'(out_tag8), 128'(v.tag));
    tick();
  endtask

  wvec_t wv [10];
  nvec_t nv [10];
  int    nn;
  sb_t   q [$];

  initial begin
    logic [W-1:0]   s1_snap, s2_snap;
    int             idx, first, last, cnt, adv;
    logic           en_s, acc, con;
    sb_t            e;

    wv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    wv[1] = '{64'd0, 64'h1234_5678_9ABC_DEF0, 4'd1, 128'd0};
    wv[2] = '{64'd1, 64'd1, 4'd2, 128'd1};
    wv[3] = '{64'h8000_0000_0000_0000, 64'd2, 4'd3, 128'h1_0000_0000_0000_0000};
    wv[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 4'd4, 128'h1_0000_0000_0000_0000};
    wv[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd15, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
    wv[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd6, 128'h1_FFFF_FFFF_FFFF_FFFE};
    wv[7] = '{64'd12345, 64'd6789, 4'd7, 128'd83810205};
    wv[8] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'd8, 128'hFFFF_FFFE_0000_0001};
    wv[9] = '{64'hDEAD_BEEF, 64'h10, 4'd10, 128'hD_EAD_BEEF_0};

    nn = 0;
    nv[nn++] = '{8'hFF, 8'hFF, 1'b0, 2'd0, 16'hFE01};
    nv[nn++] = '{8'h80, 8'h7F, 1'b0, 2'd1, 16'h3F80};
    nv[nn++] = '{8'h0F, 8'h11, 1'b0, 2'd2, 16'h00FF};
    nv[nn++] = '{8'h00, 8'hAB, 1'b0, 2'd3, 16'h0000};
    nv[nn++] = '{8'h01, 8'h01, 1'b0, 2'd0, 16'h0001};
`ifdef WALLACE_MUL_SIGNED_EN
    nv[nn++] = '{8'h80, 8'h7F, 1'b1, 2'd1, 16'hC080};
    nv[nn++] = '{8'hFF, 8'hFF, 1'b1, 2'd2, 16'h0001};
    nv[nn++] = '{8'h80, 8'h80, 1'b1, 2'd3, 16'h4000};
    nv[nn++] = '{8'h7F, 8'h7F, 1'b1, 2'd0, 16'h3F01};
    nv[nn++] = '{8'hFF, 8'h01, 1'b1, 2'd1, 16'hFFFF};
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; in_tag = '0; is_signed = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; in_tag8 = '0; is_signed8 = 1'b0;

    // Reset state
    tick();
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset s1", s1, 128'(0));
    check("reset s2", s2, 128'(0));
    check("reset out_tag", 128'(out_tag), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset in_ready8", 128'(in_ready8), 128'(1));
    check("reset out_valid8", 128'(out_valid8), 128'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Directed single beats, 64-bit
    for (int i = 0; i < 10; i++) wide_beat(wv[i], $sformatf("wide%0d", i));

    // Directed single beats, 8-bit / 6 ranks
    for (int i = 0; i < nn; i++) nar_beat(nv[i], $sformatf("nar%0d", i));

    // Back-to-back 8 beats
    idx = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        a = 64'(c + 1); b = 64'd3; in_tag = TW'(c); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        check($sformatf("b2b%0d product", idx), wsum(), 128'(3 * (idx + 1)));
        check($sformatf("b2b%0d tag", idx), 128'(out_tag), 128'(idx));
        if (first < 0) first = c;
        last = c;
        idx++;
      end
    end
    check("b2b count", 128'(idx), 128'(8));
    check("b2b first cycle", 128'(first), 128'(S - 1));
    check("b2b last cycle", 128'(last), 128'(S - 1 + 7));

    // Stall with three beats in flight and a fourth offered during the stall
    for (int i = 0; i < 3; i++) begin
      a = 64'(10 + i); b = 64'd1000; in_tag = TW'(i + 1); in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    a = 64'd7; b = 64'd7; in_tag = 4'd9; in_valid = 1'b1;
    #1;
    check("stall in_ready", 128'(in_ready), 128'(0));
    check("stall head product", wsum(), 128'd10000);
    s1_snap = s1[W-1:0];
    s2_snap = s2[W-1:0];
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("stall%0d valid", k), 128'(out_valid), 128'(1));
      check($sformatf("stall%0d in_ready", k), 128'(in_ready), 128'(0));
      check($sformatf("stall%0d product", k), wsum(), 128'd10000);
      check($sformatf("stall%0d tag", k), 128'(out_tag), 128'(1));
      check($sformatf("stall%0d s1 stable", k), 128'(s1[W-1:0]), 128'(s1_snap));
      check($sformatf("stall%0d s2 stable", k), 128'(s2[W-1:0]), 128'(s2_snap));
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("release beat1 product", wsum(), 128'd11000);
    check("release beat1 tag", 128'(out_tag), 128'(2));
    tick();
    check("release beat2 product", wsum(), 128'd12000);
    check("release beat2 tag", 128'(out_tag), 128'(3));
    tick();
    check("release beat3 product", wsum(), 128'd49);
    check("release beat3 tag", 128'(out_tag), 128'(9));
    tick();
    check("release drained", 128'(out_valid), 128'(0));

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      a = 64'd5; b = 64'(5 + i); in_tag = TW'(4 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("midrst pre valid", 128'(out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 128'(out_valid), 128'(0));
    check("midrst s1", s1, 128'(0));
    check("midrst s2", s2, 128'(0));
    check("midrst out_tag", 128'(out_tag), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("midrst no stale results", 128'(cnt), 128'(0));

    // Random beats with random back-pressure against a reference multiply
    adv = 0;
    for (int c = 0; c < 360; c++) begin
      in_valid = (c < 300) && ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       a = '1;
        1:       a = '0;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       b = '1;
        1:       b = 64'h8000_0000_0000_0000;
        default: b = {$urandom, $urandom};
      endcase
      in_tag = TW'($urandom);
      out_ready = (c >= 310) || ($urandom_range(0, 9) < 6);
      #1;
      en_s = in_ready;
      acc  = in_valid && in_ready;
      con  = out_valid && out_ready;
      if (con) begin
        if (q.size() == 0) begin
          check("rnd spurious result", 128'(out_valid), 128'(0));
        end else begin
          e = q.pop_front();
          check("rnd product", wsum(), {64'd0, e.a} * {64'd0, e.b});
          check("rnd tag", 128'(out_tag), 128'(e.tag));
          check("rnd latency", 128'(adv - e.adv), 128'(S));
        end
      end
      if (acc) q.push_back('{a, b, in_tag, adv});
      @(posedge clk);
      if (en_s) adv++;
      #1;
    end
    in_valid = 1'b0;
    check("rnd all delivered", 128'(q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
